fp_mul_arbiter: RTL and testbench
=================================

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in clk cycles (used only under FP_MUL_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester request strobe, level, held until req_ready.
REQ-006 SHALL have port req_op1  input  NREQ*32  packed IEEE-754 single operand A; slice i belongs to requester i.
REQ-007 SHALL have port req_op2  input  NREQ*32  packed IEEE-754 single operand B.
REQ-008 SHALL have port req_ready  output  NREQ  one-cycle one-hot accept pulse.
REQ-009 SHALL have port rsp_valid  output  NREQ  one-cycle one-hot result pulse.
REQ-010 SHALL have port rsp_data  output  32  product, valid while any rsp_valid bit is high.
REQ-011 SHALL have port rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-012 SHALL have port mul_op1  output  32  operand A to the shared multiplier.
REQ-013 SHALL have port mul_op2  output  32  operand B to the shared multiplier.
REQ-014 SHALL have port mul_in_rdy  output  1  start level to the shared multiplier.
REQ-015 SHALL have port mul_res  input  32  multiplier result.
REQ-016 SHALL have port mul_res_rdy  input  1  multiplier done, one-cycle pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP and FLUSH.
REQ-018 IDLE: if any req_valid is high, SHALL grant one requester by round-robin, starting at the index after the last grant; after reset the search starts at index 0.
REQ-019 On grant SHALL pulse req_ready[g] for 1 cycle, register that requester's op1/op2 into mul_op1/mul_op2, store g, and go to ISSUE.
REQ-020 ISSUE: SHALL assert mul_in_rdy (registered), then go to WAIT the next cycle.
REQ-021 WAIT: SHALL hold mul_in_rdy=1 and keep mul_op1/mul_op2 stable until mul_res_rdy=1 is sampled.
REQ-022 On sampling mul_res_rdy=1, SHALL capture mul_res into rsp_data, deassert mul_in_rdy at the same edge, and go to RESP.
REQ-023 RESP: SHALL pulse rsp_valid[g] for 1 cycle with rsp_err=0, then return to IDLE; minimum spacing between grants is 4 cycles.
REQ-024 SHALL ignore mul_res_rdy in IDLE, ISSUE and RESP; it SHALL have no effect on outputs in those states.
REQ-025 A requester that drops req_valid before its grant SHALL be skipped; req_valid of a requester already in service SHALL be ignored until its rsp_valid.
REQ-026 SHALL produce exactly one rsp_valid pulse per req_ready pulse, with the same index.

Reset
REQ-027 While rst is high, SHALL hold state=IDLE, RR pointer=0, and req_ready, rsp_valid, rsp_data, rsp_err, mul_op1, mul_op2 and mul_in_rdy all 0.
REQ-028 Reset mid-transaction SHALL abort the transaction with no rsp_valid; operation restarts from IDLE after rst falls.

Configuration
REQ-029 With FP_MUL_ARB_TIMEOUT_EN defined: SHALL count cycles in WAIT; when the count reaches TIMEOUT_CYCLES, SHALL drop mul_in_rdy, pulse rsp_valid[g] with rsp_err=1 and rsp_data=32'h7FC00000, then enter FLUSH.
REQ-030 FLUSH SHALL last TIMEOUT_CYCLES cycles, discard any mul_res_rdy, then go to IDLE.
REQ-031 Without FP_MUL_ARB_TIMEOUT_EN: no counter, no FLUSH transitions, rsp_err tied 0; WAIT persists until mul_res_rdy.

Structure
REQ-032 SHALL take FSM state encodings, the quiet-NaN constant 32'h7FC00000 and the default NREQ/TIMEOUT_CYCLES from shared package fp_mul_pkg.
REQ-033 SHALL put round-robin selection in sub-module rr_arbiter (inputs: request vector, last-grant index; outputs: one-hot grant, index, any).

Verification
REQ-034 Single request: req0 op1=0x40000000, op2=0x40400000 -> rsp_valid[0] with rsp_data=0x40C00000, rsp_err=0.
REQ-035 All 4 requesters valid continuously after reset -> grants in order 0,1,2,3,0; each rsp index matches its grant.
REQ-036 req1 op1=0x7F800000, op2=0x00000000 -> rsp_valid[1], rsp_data=0x7FC00000, rsp_err=0; mul_in_rdy low within 1 cycle after mul_res_rdy.
REQ-037 rst asserted 3 cycles into WAIT -> all outputs 0 immediately, no rsp_valid; next request after rst falls completes normally.
REQ-038 FP_MUL_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, multiplier model stalled -> rsp_err=1, rsp_data=0x7FC00000 after 8 WAIT cycles; a late mul_res_rdy during FLUSH is ignored.
REQ-039 Spurious mul_res_rdy pulse in IDLE -> no rsp_valid, state unchanged.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier arbiter: FSM encoding, the quiet-NaN
// result used on timeout, and default sizing parameters.
package fp_mul_pkg;

   localparam int DEF_NREQ           = 4;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      FLUSH = 3'd4
   } state_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the FP multiplier arbiter.
// slave = arbiter view, master = requesters plus shared multiplier view.
interface fp_mul_arbiter_if
   import fp_mul_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_op1;
   logic [NREQ*32-1:0] req_op2;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [31:0]        rsp_data;
   logic               rsp_err;
   logic [31:0]        mul_op1;
   logic [31:0]        mul_op2;
   logic               mul_in_rdy;
   logic [31:0]        mul_res;
   logic               mul_res_rdy;

   modport slave (
      input  req_valid, req_op1, req_op2, mul_res, mul_res_rdy,
      output req_ready, rsp_valid, rsp_data, rsp_err, mul_op1, mul_op2, mul_in_rdy
   );

   modport master (
      output req_valid, req_op1, req_op2, mul_res, mul_res_rdy,
      input  req_ready, rsp_valid, rsp_data, rsp_err, mul_op1, mul_op2, mul_in_rdy
   );

endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the last grant and returns the first hit as one-hot plus index.
module rr_arbiter
   import fp_mul_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   int          cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      grant    = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand     = (int'(last) + k) % NREQ;
         cand_idx = IW'(cand);
         if (!any && req[cand_idx]) begin
            any             = 1'b1;
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP multiplier among NREQ requesters with round-robin arbitration.
// Optional WAIT watchdog and FLUSH recovery enabled by FP_MUL_ARB_TIMEOUT_EN.
module fp_mul_arbiter
   import fp_mul_pkg::*;
#(
   parameter int NREQ           = DEF_NREQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic             clk,
   input logic             rst,
   fp_mul_arbiter_if.slave bus
);

   localparam int IW = $clog2(NREQ);

   state_t          state, state_nxt;
   logic [IW-1:0]   last_grant, last_grant_nxt;
   logic [IW-1:0]   cur_idx, cur_idx_nxt;
   logic [NREQ-1:0] req_ready_q, req_ready_nxt;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_nxt;
   logic [31:0]     rsp_data_q, rsp_data_nxt;
   logic [31:0]     op1_q, op1_nxt, op2_q, op2_nxt;
   logic            in_rdy_q, in_rdy_nxt;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            grant_any;

`ifdef FP_MUL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          err_q, err_nxt;
   logic          timeout_hit;

   // One counter serves both the WAIT watchdog and the FLUSH hold-off
   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (bus.req_valid),
      .last  (last_grant),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // last_grant resets to NREQ-1 so the first search after reset begins at index 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= IW'(NREQ - 1);
         cur_idx     <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         in_rdy_q    <= 1'b0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         cur_idx     <= cur_idx_nxt;
         req_ready_q <= req_ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_data_q  <= rsp_data_nxt;
         op1_q       <= op1_nxt;
         op2_q       <= op2_nxt;
         in_rdy_q    <= in_rdy_nxt;
`ifdef FP_MUL_ARB_TIMEOUT_EN
         cnt_q       <= cnt_nxt;
         err_q       <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (grant_any) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (bus.mul_res_rdy) state_nxt = RESP;
`ifdef FP_MUL_ARB_TIMEOUT_EN
                else if (timeout_hit) state_nxt = FLUSH;
         FLUSH: if (timeout_hit) state_nxt = IDLE;
`endif
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of all registered outputs; mul_res_rdy only matters in WAIT
   always_comb begin
      last_grant_nxt = last_grant;
      cur_idx_nxt    = cur_idx;
      req_ready_nxt  = '0;
      rsp_valid_nxt  = '0;
      rsp_data_nxt   = rsp_data_q;
      op1_nxt        = op1_q;
      op2_nxt        = op2_q;
      in_rdy_nxt     = in_rdy_q;
`ifdef FP_MUL_ARB_TIMEOUT_EN
      cnt_nxt        = cnt_q;
      err_nxt        = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (grant_any) begin
               req_ready_nxt  = grant;
               last_grant_nxt = grant_idx;
               cur_idx_nxt    = grant_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (grant[i]) begin
                     op1_nxt = bus.req_op1[i*32 +: 32];
                     op2_nxt = bus.req_op2[i*32 +: 32];
                  end
               end
            end
         end
         ISSUE: begin
            in_rdy_nxt = 1'b1;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            cnt_nxt    = '0;
`endif
         end
         WAIT: begin
            if (bus.mul_res_rdy) begin
               in_rdy_nxt             = 1'b0;
               rsp_data_nxt           = bus.mul_res;
               rsp_valid_nxt[cur_idx] = 1'b1;
            end
`ifdef FP_MUL_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               in_rdy_nxt             = 1'b0;
               rsp_data_nxt           = QNAN;
               err_nxt                = 1'b1;
               rsp_valid_nxt[cur_idx] = 1'b1;
               cnt_nxt                = '0;
            end else begin
               cnt_nxt = cnt_q + 1'b1;
            end
`endif
         end
`ifdef FP_MUL_ARB_TIMEOUT_EN
         FLUSH: cnt_nxt = cnt_q + 1'b1;
`endif
         default: ;
      endcase
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.mul_op1    = op1_q;
   assign bus.mul_op2    = op2_q;
   assign bus.mul_in_rdy = in_rdy_q;
`ifdef FP_MUL_ARB_TIMEOUT_EN
   assign bus.rsp_err    = err_q;
`else
   assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed requests push expected grants and
// responses; a monitor pops and compares them against the DUT's pulses.
module tb_fp_mul_arbiter;
   import fp_mul_pkg::*;

   localparam int N  = 4;
   localparam int TO = 8;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;

   rsp_t rsp_q[$];
   int   grant_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   bit mul_stall = 1'b0;
   int mul_lat   = 1;
   int spur_req  = 0;
   int spur_done = 0;

   logic [31:0] ops_a[N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   logic [31:0] prods[N] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

   always #5 clk = ~clk;

   fp_mul_arbiter_if #(.NREQ(N)) bus ();

   fp_mul_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Hand-computed IEEE-754 single products for every operand pair the bench uses
   function automatic logic [31:0] mulLookup(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40000000, 32'h40400000}: return 32'h40C00000;
         {32'h7F800000, 32'h00000000}: return 32'h7FC00000;
         {32'h3F800000, 32'h40000000}: return 32'h40000000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         {32'h40400000, 32'h40000000}: return 32'h40C00000;
         {32'h40800000, 32'h40000000}: return 32'h41000000;
         {32'h40A00000, 32'h40000000}: return 32'h41200000;
         {32'h3FC00000, 32'h40000000}: return 32'h40400000;
         default:                      return 32'hDEADBEEF;
      endcase
   endfunction

   function automatic int oneHotIdx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req_v);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req_ready"},  32'(bus.req_ready), 0);
      checkOutput({tag, "_rsp_valid"},  32'(bus.rsp_valid), 0);
      checkOutput({tag, "_rsp_data"},   bus.rsp_data, 0);
      checkOutput({tag, "_rsp_err"},    32'(bus.rsp_err), 0);
      checkOutput({tag, "_mul_op1"},    bus.mul_op1, 0);
      checkOutput({tag, "_mul_op2"},    bus.mul_op2, 0);
      checkOutput({tag, "_mul_in_rdy"}, 32'(bus.mul_in_rdy), 0);
   endtask

   // Raise one request, record what it must produce, and hold it until accepted
   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_data, input logic exp_err, input bit exp_rsp);
      int c;
      bus.req_op1[idx*32 +: 32] = a;
      bus.req_op2[idx*32 +: 32] = b;
      bus.req_valid[idx]        = 1'b1;
      grant_q.push_back(idx);
      if (exp_rsp) rsp_q.push_back(rsp_t'{idx, exp_data, exp_err});
      c = 0;
      while (!bus.req_ready[idx] && c < 50) begin
         @(negedge clk);
         c++;
      end
      checkOutput("req_ready_seen", 32'(bus.req_ready[idx]), 1);
      bus.req_valid[idx] = 1'b0;
   endtask

   task automatic waitDrained(input int budget);
      int c;
      c = 0;
      while ((rsp_q.size() != 0 || grant_q.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      checkOutput("queues_drained", 32'(rsp_q.size() + grant_q.size()), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulseReset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Shared multiplier model: answers after mul_lat cycles unless stalled
   initial begin : mul_model
      bit busy;
      int lcnt;
      busy = 1'b0;
      lcnt = 0;
      bus.mul_res     = '0;
      bus.mul_res_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.mul_res_rdy = 1'b0;
         if (rst) busy = 1'b0;
         if (spur_req != spur_done) begin
            spur_done++;
            bus.mul_res     = 32'h12345678;
            bus.mul_res_rdy = 1'b1;
         end else if (busy) begin
            if (lcnt == 0) begin
               bus.mul_res     = mulLookup(bus.mul_op1, bus.mul_op2);
               bus.mul_res_rdy = 1'b1;
               busy            = 1'b0;
            end else begin
               lcnt--;
            end
         end else if (bus.mul_in_rdy && !mul_stall) begin
            busy = 1'b1;
            lcnt = mul_lat;
         end
      end
   end

   // Monitor: every accept and result pulse is matched against the scoreboard
   initial begin : monitor
      int   g;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!rst && bus.req_ready != '0) begin
            checkOutput("grant_onehot", 32'($countones(bus.req_ready)), 1);
            if (grant_q.size() == 0) checkOutput("unexpected_grant", 32'(bus.req_ready), 0);
            else begin
               g = grant_q.pop_front();
               checkOutput("grant_index", 32'(oneHotIdx(bus.req_ready)), 32'(g));
            end
         end
         if (!rst && bus.rsp_valid != '0) begin
            checkOutput("rsp_onehot", 32'($countones(bus.rsp_valid)), 1);
            checkOutput("in_rdy_low_at_rsp", 32'(bus.mul_in_rdy), 0);
            if (rsp_q.size() == 0) checkOutput("unexpected_rsp", 32'(bus.rsp_valid), 0);
            else begin
               r = rsp_q.pop_front();
               checkOutput("rsp_index", 32'(oneHotIdx(bus.rsp_valid)), 32'(r.idx));
               checkOutput("rsp_data",  bus.rsp_data, r.data);
               checkOutput("rsp_err",   32'(bus.rsp_err), 32'(r.err));
            end
         end
      end
   end

   initial begin : stimulus
      int c;
      int n;
      int rem[N];
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_op1   = '0;
      bus.req_op2   = '0;

      // Requests raised during reset must not be accepted
      repeat (2) @(negedge clk);
      bus.req_valid = 4'b0101;
      @(negedge clk);
      checkAllZero("reset");
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Spurious multiplier done while idle
      spur_req++;
      repeat (4) @(negedge clk);
      checkOutput("spur_in_rdy", 32'(bus.mul_in_rdy), 0);
      checkOutput("spur_req_ready", 32'(bus.req_ready), 0);

      // Single requests: 2.0*3.0 and inf*0
      mul_lat = 2;
      applyStimulus(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b1);
      waitDrained(100);
      mul_lat = 0;
      applyStimulus(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1);
      waitDrained(100);
      mul_lat = 1;

      // Reset three cycles into WAIT aborts the transaction silently
      mul_stall = 1'b1;
      applyStimulus(0, 32'h40A00000, 32'h40000000, 32'h0, 1'b0, 1'b0);
      c = 0;
      while (!bus.mul_in_rdy && c < 20) begin
         @(negedge clk);
         c++;
      end
      checkOutput("wait_entered", 32'(bus.mul_in_rdy), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkAllZero("midreset");
      repeat (2) @(negedge clk);
      mul_stall = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
      waitDrained(100);

      // All requesters busy after reset: grants 0,1,2,3,0
      pulseReset(2);
      rem = '{2, 1, 1, 1};
      for (int i = 0; i < N; i++) begin
         bus.req_op1[i*32 +: 32] = ops_a[i];
         bus.req_op2[i*32 +: 32] = 32'h40000000;
      end
      for (int k = 0; k < 5; k++) begin
         grant_q.push_back(k % N);
         rsp_q.push_back(rsp_t'{k % N, prods[k % N], 1'b0});
      end
      bus.req_valid = '1;
      c = 0;
      while (bus.req_valid != '0 && c < 200) begin
         @(negedge clk);
         c++;
         for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
               rem[i]--;
               if (rem[i] == 0) bus.req_valid[i] = 1'b0;
            end
         end
      end
      checkOutput("rr_all_served", 32'(bus.req_valid), 0);
      waitDrained(100);

`ifdef FP_MUL_ARB_TIMEOUT_EN
      // Stalled multiplier: timeout after TO WAIT cycles, late done ignored in FLUSH
      mul_stall = 1'b1;
      applyStimulus(1, 32'h40000000, 32'h40000000, QNAN, 1'b1, 1'b1);
      c = 0;
      while (!bus.mul_in_rdy && c < 20) begin
         @(negedge clk);
         c++;
      end
      n = 0;
      while (bus.rsp_valid == '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_latency", 32'(n), 32'(TO));
      @(negedge clk);
      spur_req++;
      repeat (TO + 4) @(negedge clk);
      checkOutput("flush_in_rdy", 32'(bus.mul_in_rdy), 0);
      mul_stall = 1'b0;
      applyStimulus(3, 32'h40800000, 32'h40000000, 32'h41000000, 1'b0, 1'b1);
      waitDrained(100);
`else
      // Without the watchdog a slow multiplier is simply waited for
      mul_lat = 20;
      applyStimulus(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b1);
      waitDrained(100);
      mul_lat = 1;
      n = 0;
`endif

      checkOutput("final_queues_empty", 32'(rsp_q.size() + grant_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
